// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled deframing of start/data/parity/stop bits,
// with a ready/acknowledge handshake and parity, framing and overrun status.
module uart_rx_engine #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_sync,
  input  logic       tick,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BRK    = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_acc;
  logic          par_err;

  logic last_bit;
  logic sample_half;
  logic sample_full;
  logic frame_done;

  assign last_bit    = (bit_cnt == (eight ? 3'd7 : 3'd6));
  assign sample_half = tick && (tick_cnt == HALF_M1);
  assign sample_full = tick && (tick_cnt == FULL_M1);
  assign frame_done  = (state == STOP) && sample_full;

  // Deframing FSM; the start sample lands mid-bit, so every later full-period
  // sample is also mid-bit and the stop sample releases IDLE half a bit early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (sample_half) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            par_err  <= 1'b0;
            state    <= rx_sync ? IDLE : DATA;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (sample_full) begin
            tick_cnt <= '0;
            shreg    <= {rx_sync, shreg[7:1]};
            par_acc  <= par_acc ^ rx_sync;
            bit_cnt  <= bit_cnt + 3'd1;
            if (last_bit) state <= pen ? PARITY : STOP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (sample_full) begin
            tick_cnt <= '0;
            par_err  <= ((par_acc ^ rx_sync) != ohel);
            state    <= STOP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (sample_full) begin
            tick_cnt <= '0;
            state    <= rx_sync ? IDLE : BRK;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        BRK: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host-side holding registers; a completing frame takes priority over rd_ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (frame_done) begin
      rx_data <= eight ? shreg : {1'b0, shreg[7:1]};
      perr    <= par_err;
      ferr    <= ~rx_sync;
      ovf     <= rx_rdy && !rd_ack;
      rx_rdy  <= 1'b1;
    end else if (rd_ack && rx_rdy) begin
      rx_rdy <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      ovf    <= 1'b0;
    end
  end

endmodule
